// File: rtl/pong_pkg.sv
// Shared Pong field geometry, timing constants and game state encoding.
// Used by the ball engine, its axis sub-module and the AI paddle controller.
// All coordinates are 10-bit screen pixels, top-left origin.
package pong_pkg;

  localparam logic [9:0] Y_MIN     = 10'd30;
  localparam logic [9:0] Y_MAX     = 10'd450;
  localparam logic [9:0] X_MAX     = 10'd630;
  localparam logic [9:0] BALL_SIZE = 10'd10;
  localparam logic [9:0] PADDLE_H  = 10'd60;
  localparam logic [9:0] P1_FACE_X = 10'd30;
  localparam logic [9:0] P2_FACE_X = 10'd600;
  localparam logic [9:0] STEP      = 10'd2;
  localparam logic [9:0] CENTRE_X  = 10'd315;
  localparam logic [9:0] CENTRE_Y  = 10'd235;

  localparam logic [5:0] SERVE_TICKS = 6'd60;
  localparam logic [3:0] WIN_SCORE   = 4'd9;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Vertical overlap of the ball with a paddle; 11-bit math so that
  // out-of-range paddle values never wrap.
  function automatic logic overlaps(input logic [9:0] ball_y, input logic [9:0] paddle_y);
    logic [10:0] b_top;
    logic [10:0] b_bot;
    logic [10:0] p_top;
    logic [10:0] p_bot;
    b_top = {1'b0, ball_y};
    b_bot = b_top + {1'b0, BALL_SIZE};
    p_top = {1'b0, paddle_y};
    p_bot = p_top + {1'b0, PADDLE_H};
    return (b_bot > p_top) && (b_top < p_bot);
  endfunction

  // Score increment that saturates at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
  endfunction

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: position and direction register with step,
// clamp at LO/HI (optionally reflecting there) and an external bounce request.
// Updates land one cycle after a move/recentre request; recentre wins over move.
module ball_axis
  import pong_pkg::*;
#(
  parameter logic [9:0] LO          = 10'd0,
  parameter logic [9:0] HI          = 10'd630,
  parameter logic [9:0] CENTRE      = 10'd315,
  parameter bit         WALL_BOUNCE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move,
  input  logic       hit,
  input  logic [9:0] hit_pos,
  input  logic       recentre,
  input  logic       load_dir,
  input  logic       dir_in,
  output logic [9:0] pos,
  output logic       dir,
  output logic [9:0] pos_nxt
);

  logic        dir_nxt;
  logic [10:0] fwd;
  logic [10:0] lo_guard;

  // Next position/direction: recentre, paddle bounce, or step with clamp.
  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    fwd      = {1'b0, pos} + {1'b0, STEP};
    lo_guard = {1'b0, LO} + {1'b0, STEP};
    if (recentre) begin
      pos_nxt = CENTRE;
      if (load_dir) begin
        dir_nxt = dir_in;
      end
    end else if (move) begin
      if (hit) begin
        pos_nxt = hit_pos;
        dir_nxt = ~dir;
      end else if (dir) begin
        if (fwd >= {1'b0, HI}) begin
          pos_nxt = HI;
          if (WALL_BOUNCE) begin
            dir_nxt = 1'b0;
          end
        end else begin
          pos_nxt = fwd[9:0];
        end
      end else begin
        if ({1'b0, pos} <= lo_guard) begin
          pos_nxt = LO;
          if (WALL_BOUNCE) begin
            dir_nxt = 1'b1;
          end
        end else begin
          pos_nxt = pos - STEP;
        end
      end
    end
  end

  // Position/direction register; reset parks the ball at centre heading positive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= CENTRE;
      dir <= 1'b1;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: moves the ball once per frame tick, bounces off walls and
// paddles, detects misses, keeps scores and sequences SERVE/PLAY/POINT/OVER.
// All outputs registered; motion visible the cycle after the tick.
module ball_engine
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] paddle_1Y,
  input  logic [9:0] paddle_2Y,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       point_1,
  output logic       point_2,
  output logic       in_play,
  output logic       game_over
);

  localparam logic [5:0] SERVE_LAST = SERVE_TICKS - 6'd1;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  serve_cnt;
  logic [5:0]  serve_cnt_nxt;
  logic [3:0]  score_1_nxt;
  logic [3:0]  score_2_nxt;
  logic        scorer_1;
  logic        scorer_1_nxt;
  logic        point_1_nxt;
  logic        point_2_nxt;

  logic [9:0]  x_pos;
  logic        x_dir;
  logic [9:0]  x_pos_nxt;
  logic [9:0]  y_pos;
  logic        y_dir;
  logic [9:0]  y_pos_nxt;

  logic        move;
  logic        recentre;
  logic [10:0] x_fwd;
  logic        hit_right;
  logic        hit_left;
  logic        x_hit;
  logic [9:0]  x_hit_pos;
  logic        unused_y;

  assign move     = tick && (state == PLAY);
  assign recentre = (state == POINT);
  assign x_fwd    = {1'b0, x_pos} + {1'b0, STEP};

  // Paddle bounce: the ball crosses a face this tick while overlapping that
  // paddle vertically (pre-tick Y). The face snaps the ball to the face X.
  assign hit_right = x_dir && (x_pos < P2_FACE_X) && ({1'b0, P2_FACE_X} <= x_fwd)
                     && overlaps(y_pos, paddle_2Y);
  assign hit_left  = !x_dir && (x_pos > P1_FACE_X)
                     && (({1'b0, P1_FACE_X} + {1'b0, STEP}) >= {1'b0, x_pos})
                     && overlaps(y_pos, paddle_1Y);
  assign x_hit     = hit_right || hit_left;
  assign x_hit_pos = hit_right ? P2_FACE_X : P1_FACE_X;

  // X saturates at the screen edges; reaching an edge is a miss, not a bounce.
  // After a point the ball heads toward the player who conceded.
  ball_axis #(
    .LO         (10'd0),
    .HI         (X_MAX),
    .CENTRE     (CENTRE_X),
    .WALL_BOUNCE(1'b0)
  ) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .move    (move),
    .hit     (x_hit),
    .hit_pos (x_hit_pos),
    .recentre(recentre),
    .load_dir(1'b1),
    .dir_in  (scorer_1),
    .pos     (x_pos),
    .dir     (x_dir),
    .pos_nxt (x_pos_nxt)
  );

  // Y reflects off the top and bottom walls; its direction survives a point.
  ball_axis #(
    .LO         (Y_MIN),
    .HI         (Y_MAX),
    .CENTRE     (CENTRE_Y),
    .WALL_BOUNCE(1'b1)
  ) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .move    (move),
    .hit     (1'b0),
    .hit_pos (10'd0),
    .recentre(recentre),
    .load_dir(1'b0),
    .dir_in  (1'b0),
    .pos     (y_pos),
    .dir     (y_dir),
    .pos_nxt (y_pos_nxt)
  );

  assign unused_y = ^{y_dir, y_pos_nxt};
  assign ballX    = x_pos;
  assign ballY    = y_pos;

  // Next-state, serve counter and scoring decisions.
  always_comb begin
    state_nxt     = state;
    serve_cnt_nxt = serve_cnt;
    score_1_nxt   = score_1;
    score_2_nxt   = score_2;
    scorer_1_nxt  = scorer_1;
    point_1_nxt   = 1'b0;
    point_2_nxt   = 1'b0;
    case (state)
      SERVE: begin
        if (tick) begin
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt_nxt = 6'd0;
            state_nxt     = PLAY;
          end else begin
            serve_cnt_nxt = serve_cnt + 6'd1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          if (x_pos_nxt == X_MAX) begin
            state_nxt    = POINT;
            scorer_1_nxt = 1'b1;
          end else if (x_pos_nxt == 10'd0) begin
            state_nxt    = POINT;
            scorer_1_nxt = 1'b0;
          end
        end
      end
      POINT: begin
        if (scorer_1) begin
          score_1_nxt = sat_inc(score_1);
          point_1_nxt = 1'b1;
          state_nxt   = (score_1_nxt == WIN_SCORE) ? OVER : SERVE;
        end else begin
          score_2_nxt = sat_inc(score_2);
          point_2_nxt = 1'b1;
          state_nxt   = (score_2_nxt == WIN_SCORE) ? OVER : SERVE;
        end
      end
      OVER: begin
        if (start) begin
          score_1_nxt   = 4'd0;
          score_2_nxt   = 4'd0;
          serve_cnt_nxt = 6'd0;
          state_nxt     = SERVE;
        end
      end
      default: begin
        state_nxt = SERVE;
      end
    endcase
  end

  // State, counter, score and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SERVE;
      serve_cnt <= 6'd0;
      score_1   <= 4'd0;
      score_2   <= 4'd0;
      scorer_1  <= 1'b0;
      point_1   <= 1'b0;
      point_2   <= 1'b0;
      in_play   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      serve_cnt <= serve_cnt_nxt;
      score_1   <= score_1_nxt;
      score_2   <= score_2_nxt;
      scorer_1  <= scorer_1_nxt;
      point_1   <= point_1_nxt;
      point_2   <= point_2_nxt;
      in_play   <= (state_nxt == PLAY);
      game_over <= (state_nxt == OVER);
    end
  end

endmodule
